// File: rtl/pwm_multi.sv
// pwm_multi: CHANNELS PWM outputs driven from one shared programmable-period
// counter. Period and per-channel duty values are written into shadow
// registers and copied to the active set only at a period boundary (or while
// idle), so a running waveform never glitches mid-period.
// Optional feature macro: PWM_MULTI_CENTER_EN adds a `center` input selecting
// centre-aligned (up/down) counting.
module pwm_multi #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 8,
  parameter int DEFAULT_PERIOD = 100,
  localparam int SELW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                period_wr,
  input  logic [WIDTH-1:0]    period_val,
  input  logic                duty_wr,
  input  logic [SELW-1:0]     duty_sel,
  input  logic [WIDTH-1:0]    duty_val,
`ifdef PWM_MULTI_CENTER_EN
  input  logic                center,
`endif
  output logic [CHANNELS-1:0] out,
  output logic                period_start,
  output logic                pending
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period_sh;
  logic [WIDTH-1:0] period_act;
  logic [WIDTH-1:0] duty_sh  [CHANNELS];
  logic [WIDTH-1:0] duty_act [CHANNELS];
  logic [WIDTH-1:0] last;
  logic             run;
  logic             wrap;
  logic             commit;
  logic             duty_ok;
  logic             wr_any;

`ifdef PWM_MULTI_CENTER_EN
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  dir_t dir;
  logic center_sh;
  logic center_act;
`endif

  // Boundary detection: wrap point of the active period and commit condition.
  always_comb begin
    run     = en && (period_act != '0);
    last    = period_act - ONE;
    duty_ok = duty_wr && (int'(duty_sel) < CHANNELS);
    wr_any  = duty_ok || period_wr;
    wrap    = 1'b0;
    if (run) begin
      wrap = (cnt == last);
`ifdef PWM_MULTI_CENTER_EN
      // P==2 has no downward leg, so the top of the ramp is already the wrap.
      if (center_act && (period_act != ONE))
        wrap = (dir == DIR_DOWN) ? (cnt == ONE) : ((cnt == last) && (period_act == TWO));
`endif
    end
    commit = wrap || !run;
  end

  // Counter, registered outputs, shadow writes and boundary commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      out          <= '0;
      period_start <= 1'b0;
      pending      <= 1'b0;
      period_sh    <= WIDTH'(DEFAULT_PERIOD);
      period_act   <= WIDTH'(DEFAULT_PERIOD);
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
`ifdef PWM_MULTI_CENTER_EN
      dir        <= DIR_UP;
      center_sh  <= 1'b0;
      center_act <= 1'b0;
`endif
    end else begin
      if (!run || wrap) begin
        cnt <= '0;
`ifdef PWM_MULTI_CENTER_EN
        dir <= DIR_UP;
      end else if (center_act && (period_act != ONE)) begin
        if (dir == DIR_UP && cnt == last) begin
          dir <= DIR_DOWN;
          cnt <= cnt - ONE;
        end else if (dir == DIR_UP) begin
          cnt <= cnt + ONE;
        end else begin
          cnt <= cnt - ONE;
        end
`endif
      end else begin
        cnt <= cnt + ONE;
      end

      for (int unsigned i = 0; i < CHANNELS; i++)
        out[i] <= run && (cnt < duty_act[i]);
      period_start <= run && (cnt == '0);

      // Commit reads the shadows before this cycle's write lands in them.
      if (commit) begin
        period_act <= period_sh;
        duty_act   <= duty_sh;
`ifdef PWM_MULTI_CENTER_EN
        center_act <= center_sh;
`endif
      end

      if (period_wr) begin
        period_sh <= period_val;
`ifdef PWM_MULTI_CENTER_EN
        center_sh <= center;
`endif
      end
      if (duty_ok)
        duty_sh[duty_sel] <= duty_val;

      if (wr_any)
        pending <= 1'b1;
      else if (commit)
        pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: self-checking bench for pwm_multi against a phase-based
// reference model of the double-buffered multi-channel PWM.
module tb_pwm_multi;
  localparam int CH = 5;
  localparam int W  = 8;
  localparam int DP = 100;
  localparam int SW = $clog2(CH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          period_wr = 1'b0;
  logic [W-1:0]  period_val = '0;
  logic          duty_wr = 1'b0;
  logic [SW-1:0] duty_sel = '0;
  logic [W-1:0]  duty_val = '0;
`ifdef PWM_MULTI_CENTER_EN
  logic          center = 1'b0;
`endif
  logic [CH-1:0] out;
  logic          period_start;
  logic          pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_multi #(
    .CHANNELS(CH),
    .WIDTH(W),
    .DEFAULT_PERIOD(DP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .period_wr(period_wr),
    .period_val(period_val),
    .duty_wr(duty_wr),
    .duty_sel(duty_sel),
    .duty_val(duty_val),
`ifdef PWM_MULTI_CENTER_EN
    .center(center),
`endif
    .out(out),
    .period_start(period_start),
    .pending(pending)
  );

  // Reference model: position within the period (m_k) is tracked as a phase
  // index; the counter value seen by the compare is derived arithmetically.
  int            m_P, s_P, m_k, len, c;
  int            m_D [CH];
  int            s_D [CH];
  bit            m_C, s_C, m_pend, m_ps, run, bnd, wr_ok;
  logic [CH-1:0] m_out = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_P = DP; s_P = DP; m_C = 0; s_C = 0; m_k = 0;
      m_pend = 0; m_ps = 0; m_out = '0;
      for (int i = 0; i < CH; i++) begin m_D[i] = 0; s_D[i] = 0; end
    end else begin
      run = en && (m_P != 0);
      if (m_C && m_P >= 2) begin
        len = 2 * m_P - 2;
        c   = (m_k < m_P) ? m_k : len - m_k;
      end else begin
        len = m_P;
        c   = m_k;
      end
      for (int i = 0; i < CH; i++) m_out[i] = run && (c < m_D[i]);
      m_ps = run && (c == 0);
      bnd  = !run || (m_k == len - 1);
      m_k  = bnd ? 0 : m_k + 1;
      if (bnd) begin m_P = s_P; m_C = s_C; m_D = s_D; end
      wr_ok = period_wr || (duty_wr && int'(duty_sel) < CH);
      if (period_wr) begin
        s_P = int'(period_val);
`ifdef PWM_MULTI_CENTER_EN
        s_C = center;
`endif
      end
      if (duty_wr && int'(duty_sel) < CH) s_D[duty_sel] = int'(duty_val);
      m_pend = wr_ok ? 1'b1 : (bnd ? 1'b0 : m_pend);
    end
  end

  task automatic wr_duty(input int sel, input int val);
    duty_sel = SW'(sel); duty_val = W'(val); duty_wr = 1'b1;
    @(negedge clk);
    duty_wr = 1'b0;
  endtask

  task automatic wr_period(input int val);
    period_val = W'(val); period_wr = 1'b1;
    @(negedge clk);
    period_wr = 1'b0;
  endtask

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (out !== '0) begin bad++; $display("FAIL reset_out got=%b exp=0", out); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL reset_ps got=%b exp=0", period_start); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0", pending); end
    rst = 1'b0;
    @(negedge clk);
    total++; if ({out, period_start, pending} !== '0) begin bad++; $display("FAIL idle_after_reset got=%b exp=0", {out, period_start, pending}); end
  endtask

  task automatic test_default_period();
    bit ok; int hi = 0; int npk = 0;
    en = 1'b0;
    wr_duty(0, 50);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL dp_pend_set got=%b exp=1", pending); end
    @(negedge clk);
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL dp_pend_idle_commit got=%b exp=0", pending); end
    en = 1'b1;
    wait_ps(ok);
    total++; if (!ok) begin bad++; $display("FAIL dp_wait_ps got=timeout exp=pulse"); end
    for (int j = 0; j < 200; j++) begin
      if (out[0]) hi++;
      if (period_start) npk++;
      total++;
      if ({out, period_start, pending} !== {m_out, m_ps, m_pend}) begin
        bad++; $display("FAIL dp_model got=%b/%b/%b exp=%b/%b/%b", out, period_start, pending, m_out, m_ps, m_pend);
      end
      @(negedge clk);
    end
    total++; if (hi !== 100) begin bad++; $display("FAIL dp_high_cycles got=%0d exp=100", hi); end
    total++; if (npk !== 2) begin bad++; $display("FAIL dp_period_starts got=%0d exp=2", npk); end
  endtask

  task automatic test_midperiod_update();
    bit ok; int h1 = 0; int h2 = 0;
    en = 1'b0;
    wr_period(10);
    wr_duty(0, 3);
    for (int i = 1; i < CH; i++) wr_duty(i, int'($urandom_range(0, 12)));
    @(negedge clk);
    en = 1'b1;
    wait_ps(ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_wait_ps got=timeout exp=pulse"); end
    for (int j = 0; j < 20; j++) begin
      if (out[0]) begin if (j < 10) h1++; else h2++; end
      if (j == 4) begin total++; if (pending !== 1'b1) begin bad++; $display("FAIL mid_pend_set got=%b exp=1", pending); end end
      if (j == 9) begin total++; if (pending !== 1'b0) begin bad++; $display("FAIL mid_pend_clear got=%b exp=0", pending); end end
      total++;
      if ({out, period_start, pending} !== {m_out, m_ps, m_pend}) begin
        bad++; $display("FAIL mid_model got=%b/%b/%b exp=%b/%b/%b", out, period_start, pending, m_out, m_ps, m_pend);
      end
      duty_wr = 1'b0;
      if (j == 3) begin duty_sel = '0; duty_val = W'(7); duty_wr = 1'b1; end
      @(negedge clk);
    end
    duty_wr = 1'b0;
    total++; if (h1 !== 3) begin bad++; $display("FAIL mid_old_duty got=%0d exp=3", h1); end
    total++; if (h2 !== 7) begin bad++; $display("FAIL mid_new_duty got=%0d exp=7", h2); end
  endtask

  task automatic test_wrap_write();
    bit ok; int h [3] = '{0, 0, 0};
    en = 1'b0;
    wr_duty(0, 2);
    @(negedge clk);
    en = 1'b1;
    wait_ps(ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_wait_ps got=timeout exp=pulse"); end
    for (int j = 0; j < 30; j++) begin
      if (out[0]) h[j / 10]++;
      if (j == 9 || j == 18) begin total++; if (pending !== 1'b1) begin bad++; $display("FAIL wrap_pend_held j=%0d got=%b exp=1", j, pending); end end
      if (j == 19) begin total++; if (pending !== 1'b0) begin bad++; $display("FAIL wrap_pend_clear got=%b exp=0", pending); end end
      duty_wr = 1'b0;
      if (j == 8) begin duty_sel = '0; duty_val = W'(6); duty_wr = 1'b1; end
      @(negedge clk);
    end
    duty_wr = 1'b0;
    total++; if (h[0] !== 2) begin bad++; $display("FAIL wrap_p1 got=%0d exp=2", h[0]); end
    total++; if (h[1] !== 2) begin bad++; $display("FAIL wrap_p2 got=%0d exp=2", h[1]); end
    total++; if (h[2] !== 6) begin bad++; $display("FAIL wrap_p3 got=%0d exp=6", h[2]); end
  endtask

  task automatic test_boundaries();
    bit ok; int h [4] = '{0, 0, 0, 0}; int any = 0;
    en = 1'b0;
    wr_duty(0, 0); wr_duty(1, 10); wr_duty(2, 255); wr_duty(3, 5);
    @(negedge clk);
    en = 1'b1;
    wait_ps(ok);
    total++; if (!ok) begin bad++; $display("FAIL bnd_wait_ps got=timeout exp=pulse"); end
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < 4; i++) if (out[i]) h[i]++;
      @(negedge clk);
    end
    total++; if (h[0] !== 0)  begin bad++; $display("FAIL bnd_d0 got=%0d exp=0", h[0]); end
    total++; if (h[1] !== 20) begin bad++; $display("FAIL bnd_d_eq_p got=%0d exp=20", h[1]); end
    total++; if (h[2] !== 20) begin bad++; $display("FAIL bnd_d255 got=%0d exp=20", h[2]); end
    total++; if (h[3] !== 10) begin bad++; $display("FAIL bnd_d5 got=%0d exp=10", h[3]); end
    wr_period(0);
    repeat (12) @(negedge clk);
    for (int j = 0; j < 30; j++) begin
      if (out !== '0 || period_start !== 1'b0) any++;
      @(negedge clk);
    end
    total++; if (any !== 0) begin bad++; $display("FAIL bnd_p0_quiet got=%0d exp=0", any); end
    wr_duty(3, 7);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL bnd_p0_pend_set got=%b exp=1", pending); end
    @(negedge clk);
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL bnd_p0_immediate got=%b exp=0", pending); end
  endtask

  task automatic test_reset_mid();
    bit ok; int hi = 0; int npk = 0;
    en = 1'b0;
    wr_period(100);
    for (int i = 0; i < 4; i++) wr_duty(i, int'($urandom_range(1, 99)));
    @(negedge clk);
    en = 1'b1;
    wait_ps(ok);
    total++; if (!ok) begin bad++; $display("FAIL rm_wait_ps got=timeout exp=pulse"); end
    repeat (56) @(negedge clk);
    rst = 1'b1;
    duty_sel = SW'(1); duty_val = W'(77); duty_wr = 1'b1;
    period_val = W'(20); period_wr = 1'b1;
    @(negedge clk);
    rst = 1'b0; duty_wr = 1'b0; period_wr = 1'b0;
    total++; if ({out, period_start, pending} !== '0) begin bad++; $display("FAIL rm_cleared got=%b exp=0", {out, period_start, pending}); end
    wait_ps(ok);
    total++; if (!ok) begin bad++; $display("FAIL rm_wait_ps2 got=timeout exp=pulse"); end
    for (int j = 0; j < 100; j++) begin
      if (out !== '0) hi++;
      if (period_start) npk++;
      @(negedge clk);
    end
    total++; if (hi !== 0) begin bad++; $display("FAIL rm_duty_zero got=%0d exp=0", hi); end
    total++; if (npk !== 1 || period_start !== 1'b1) begin bad++; $display("FAIL rm_period_100 got=%0d/%b exp=1/1", npk, period_start); end
    for (int s = 5; s < 8; s++) begin
      duty_sel = SW'(s); duty_val = W'(9); duty_wr = 1'b1;
      @(negedge clk);
    end
    duty_wr = 1'b0;
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL rm_bad_sel got=%b exp=0", pending); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 800; j++) begin
      total++;
      if ({out, period_start, pending} !== {m_out, m_ps, m_pend}) begin
        bad++; $display("FAIL rnd_model j=%0d got=%b/%b/%b exp=%b/%b/%b", j, out, period_start, pending, m_out, m_ps, m_pend);
      end
      duty_wr    = ($urandom_range(0, 3) == 0);
      duty_sel   = SW'($urandom_range(0, 7));
      duty_val   = W'($urandom_range(0, 15));
      period_wr  = ($urandom_range(0, 19) == 0);
      period_val = W'($urandom_range(0, 12));
      en         = ($urandom_range(0, 29) != 0);
      rst        = ($urandom_range(0, 299) == 0);
`ifdef PWM_MULTI_CENTER_EN
      center     = 1'($urandom_range(0, 1));
`endif
      @(negedge clk);
    end
    duty_wr = 1'b0; period_wr = 1'b0; rst = 1'b0; en = 1'b0;
  endtask

`ifdef PWM_MULTI_CENTER_EN
  task automatic test_center();
    bit ok; int hi = 0; int npk = 0;
    en = 1'b0; center = 1'b1;
    wr_period(8);
    wr_duty(0, 3);
    @(negedge clk);
    en = 1'b1;
    wait_ps(ok);
    total++; if (!ok) begin bad++; $display("FAIL ctr_wait_ps got=timeout exp=pulse"); end
    for (int j = 0; j < 14; j++) begin
      if (out[0]) hi++;
      if (period_start) npk++;
      total++;
      if (out[0] !== (j <= 2 || j >= 12)) begin bad++; $display("FAIL ctr_shape j=%0d got=%b exp=%b", j, out[0], (j <= 2 || j >= 12)); end
      @(negedge clk);
    end
    total++; if (hi !== 5) begin bad++; $display("FAIL ctr_width got=%0d exp=5", hi); end
    total++; if (npk !== 1 || period_start !== 1'b1) begin bad++; $display("FAIL ctr_period14 got=%0d/%b exp=1/1", npk, period_start); end
    center = 1'b0;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_default_period();
    test_midperiod_update();
    test_wrap_write();
    test_boundaries();
    test_reset_mid();
    test_random();
`ifdef PWM_MULTI_CENTER_EN
    test_center();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
